// File: rtl/gate_sweep_checker_if.sv
// Bundle between a gate sweep exerciser and whoever hosts it.
// The slave side is the checker. The master side supplies the start/mode request
// and the gate-under-test output, and observes the stimulus and the results.
interface gate_sweep_checker_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 8
);
    logic              start;
    logic [2:0]        mode;
    logic              dut_y;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [N_IN-1:0]   first_fail_vec;
    logic              first_fail_valid;

    modport master (
        output start, mode, dut_y,
        input  vec_out, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, mode, dut_y,
        output vec_out, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: clocked exerciser for an N_IN-input combinational gate.
// It walks vec_out through all 2^N_IN values, holds each for SETTLE cycles, then
// samples dut_y once and compares it against a reference model of the gate chosen
// by mode (latched at start). It reports the mismatch count, the first failing
// vector and a pass flag.
// Optional build macro STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module gate_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_sweep_checker_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // The settle counter runs 0..SETTLE-1 while in DRIVE
    localparam int               CNT_W    = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]  first_fail_vec_q, first_fail_vec_d;
    logic             first_fail_valid_q, first_fail_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             exp_y;
    logic             mismatch;
    logic             stop_now;

    // Reference model: expected gate output for a vector. NOT/BUF look at bit 0 only.
    function automatic logic ref_gate(input logic [2:0] m, input logic [N_IN-1:0] v);
        logic y;
        case (m)
            3'd0:    y = &v;
            3'd1:    y = |v;
            3'd2:    y = ~&v;
            3'd3:    y = ~|v;
            3'd4:    y = ^v;
            3'd5:    y = ~^v;
            3'd6:    y = ~v[0];
            default: y = v[0];
        endcase
        return y;
    endfunction

    // Error counter increment that sticks at all-ones instead of wrapping
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    // Next-state and datapath for the sweep sequence
    always_comb begin
        state_d            = state_q;
        mode_d             = mode_q;
        vec_d              = vec_q;
        cnt_d              = cnt_q;
        err_cnt_d          = err_cnt_q;
        first_fail_vec_d   = first_fail_vec_q;
        first_fail_valid_d = first_fail_valid_q;
        busy_d             = busy_q;
        done_d             = 1'b0;
        pass_d             = pass_q;

        exp_y    = ref_gate(mode_q, vec_q);
        // Case-inequality so an X/Z gate output is counted as a mismatch
        mismatch = (bus.dut_y !== exp_y);
        stop_now = 1'b0;
`ifdef STOP_ON_FAIL_EN
        stop_now = mismatch;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d             = bus.mode;
                    err_cnt_d          = '0;
                    first_fail_vec_d   = '0;
                    first_fail_valid_d = 1'b0;
                    pass_d             = 1'b0;
                    vec_d              = '0;
                    cnt_d              = '0;
                    busy_d             = 1'b1;
                    state_d            = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    if (!first_fail_valid_q) begin
                        first_fail_vec_d   = vec_q;
                        first_fail_valid_d = 1'b1;
                    end
                end
                if ((&vec_q) || stop_now) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                // err_cnt_q already includes the last SAMPLE's result here
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_cnt_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= S_IDLE;
            mode_q             <= '0;
            vec_q              <= '0;
            cnt_q              <= '0;
            err_cnt_q          <= '0;
            first_fail_vec_q   <= '0;
            first_fail_valid_q <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            mode_q             <= mode_d;
            vec_q              <= vec_d;
            cnt_q              <= cnt_d;
            err_cnt_q          <= err_cnt_d;
            first_fail_vec_q   <= first_fail_vec_d;
            first_fail_valid_q <= first_fail_valid_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            pass_q             <= pass_d;
        end
    end

    assign bus.vec_out          = vec_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_cnt          = err_cnt_q;
    assign bus.first_fail_vec   = first_fail_vec_q;
    assign bus.first_fail_valid = first_fail_valid_q;

endmodule
